// File: rtl/shuffle_rd_issuer_pkg.sv
// Shared types and helpers for the inner-shuffle read issuer.
// Holds the FSM state type and tile sizing functions.
package shuffle_pkg;

  typedef enum logic {IDLE, ISSUE} shuffle_rd_state_t;

  function automatic int tile_words(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Counter width that stays at least one bit for single-entry ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shuffle_rd_issuer_if.sv
// Bundle of the tile handshake, memory read-request/read-data channels
// and the downstream stream port of the shuffle read issuer.
interface shuffle_rd_issuer_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
);
  logic              tile_vld;
  logic              tile_rdy;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_req_vld;
  logic              rd_req_rdy;
  logic [WIDTH-1:0]  rd_dat;
  logic              rd_dat_vld;
  logic              rd_dat_rdy;
  logic [WIDTH-1:0]  out_dat;
  logic              out_vld;
  logic              out_rdy;
  logic              out_last;
  logic              tile_done;

  modport master (
    input  tile_vld, rd_req_rdy, rd_dat, rd_dat_vld, out_rdy,
    output tile_rdy, rd_addr, rd_req_vld, rd_dat_rdy, out_dat, out_vld,
           out_last, tile_done
  );

  modport slave (
    output tile_vld, rd_req_rdy, rd_dat, rd_dat_vld, out_rdy,
    input  tile_rdy, rd_addr, rd_req_vld, rd_dat_rdy, out_dat, out_vld,
           out_last, tile_done
  );
endinterface

// File: rtl/shuffle_rd_issuer_addr_gen.sv
// Column-major address walker over a row-major tile in a 2-bank buffer.
// Row index is the inner loop; the bank flips on the last request of a tile.
module shuffle_addr_gen
  import shuffle_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last_req
);
  localparam int TW  = tile_words(ROWS, COLS);
  localparam int R_W = cnt_width(ROWS);
  localparam int C_W = cnt_width(COLS);

  logic              bank;
  logic              bank_nxt;
  logic [R_W-1:0]    r;
  logic [C_W-1:0]    c;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base_nxt;

  assign last_req = (r == R_W'(ROWS - 1)) && (c == C_W'(COLS - 1));
  assign bank_nxt = bank ^ (step && last_req);
  assign base     = bank ? ADDR_W'(TW) : '0;
  // A tile accepted together with the previous tile's last request lands in the flipped bank.
  assign base_nxt = bank_nxt ? ADDR_W'(TW) : '0;
  assign addr     = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= 1'b0;
      r    <= '0;
      c    <= '0;
      ptr  <= '0;
    end else begin
      bank <= bank_nxt;
      if (start) begin
        r   <= '0;
        c   <= '0;
        ptr <= base_nxt;
      end else if (step) begin
        if (r != R_W'(ROWS - 1)) begin
          r   <= r + R_W'(1);
          ptr <= ptr + ADDR_W'(COLS);
        end else begin
          r   <= '0;
          c   <= last_req ? '0 : c + C_W'(1);
          ptr <= base + ADDR_W'(c) + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/shuffle_rd_issuer.sv
// Transposing read issuer for the inner-shuffle buffer with a pass-through output stream.
// Optional request credit limiting is enabled by defining SHUFFLE_RD_CREDIT_EN.
module shuffle_rd_issuer
  import shuffle_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                rst,
  shuffle_rd_issuer_if.master bus
);
  localparam int TW     = tile_words(ROWS, COLS);
  localparam int ADDR_W = $clog2(2 * TW);
  localparam int BEAT_W = cnt_width(TW);

  if (WIDTH < 1 || ROWS < 1 || COLS < 1 || MAX_OUTSTANDING < 1) begin : g_param_check
    $error("shuffle_rd_issuer: WIDTH, ROWS, COLS and MAX_OUTSTANDING must be >= 1");
  end

  shuffle_rd_state_t state;
  shuffle_rd_state_t state_nxt;

  logic              credit_ok;
  logic              req_fire;
  logic              last_req;
  logic              last_req_fire;
  logic              tile_fire;
  logic              out_fire;
  logic              beat_last;
  logic [BEAT_W-1:0] beat_cnt;

  assign bus.rd_req_vld = (state == ISSUE) && credit_ok;
  assign req_fire       = bus.rd_req_vld && bus.rd_req_rdy;
  assign last_req_fire  = req_fire && last_req;
  assign bus.tile_rdy   = (state == IDLE) || last_req_fire;
  assign tile_fire      = bus.tile_vld && bus.tile_rdy;

  assign bus.out_dat    = bus.rd_dat;
  assign bus.out_vld    = bus.rd_dat_vld;
  assign bus.rd_dat_rdy = bus.out_rdy;
  assign out_fire       = bus.rd_dat_vld && bus.out_rdy;
  assign beat_last      = (beat_cnt == BEAT_W'(TW - 1));
  assign bus.out_last   = bus.rd_dat_vld && beat_last;

  shuffle_addr_gen #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (tile_fire),
    .step     (req_fire),
    .addr     (bus.rd_addr),
    .last_req (last_req)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stay in ISSUE across tiles when the next one is offered on the last request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.tile_vld) state_nxt = ISSUE;
      ISSUE:   if (last_req_fire && !bus.tile_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The drain side counts beats on its own so it can overlap the next tile's issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt      <= '0;
      bus.tile_done <= 1'b0;
    end else begin
      bus.tile_done <= out_fire && beat_last;
      if (out_fire) beat_cnt <= beat_last ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

`ifdef SHUFFLE_RD_CREDIT_EN
  localparam int CRD_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CRD_W-1:0] outstanding;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, out_fire})
        2'b10:   outstanding <= outstanding + CRD_W'(1);
        2'b01:   outstanding <= outstanding - CRD_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign credit_ok = (outstanding != CRD_W'(MAX_OUTSTANDING));

  credit_overflow: assert property (@(posedge clk) disable iff (rst)
    outstanding <= CRD_W'(MAX_OUTSTANDING));
`else
  assign credit_ok = 1'b1;
`endif

endmodule

// File: tb/tb_shuffle_rd_issuer.sv
// Randomized bench for shuffle_rd_issuer: a 2x3 and a 1x4 instance, each fed by a
// 3-cycle-latency memory whose data equals its address, checked against a tile-level model.
module tb_shuffle_rd_issuer;

`ifdef SHUFFLE_RD_CREDIT_EN
  localparam int MAXO = 2;
`else
  localparam int MAXO = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shuffle_rd_issuer_if #(.WIDTH(8), .ADDR_W(4)) if0 ();
  shuffle_rd_issuer_if #(.WIDTH(8), .ADDR_W(3)) if1 ();

  shuffle_rd_issuer #(.WIDTH(8), .ROWS(2), .COLS(3), .MAX_OUTSTANDING(MAXO)) dut0 (
    .clk (clk), .rst (rst), .bus (if0));
  shuffle_rd_issuer #(.WIDTH(8), .ROWS(1), .COLS(4), .MAX_OUTSTANDING(MAXO)) dut1 (
    .clk (clk), .rst (rst), .bus (if1));

  int rows_a[2] = '{2, 1};
  int cols_a[2] = '{3, 4};

  logic       tv[2], rrdy[2], orr[2], dvld[2];
  logic [7:0] dat[2];

  assign if0.tile_vld = tv[0];   assign if1.tile_vld = tv[1];
  assign if0.rd_req_rdy = rrdy[0]; assign if1.rd_req_rdy = rrdy[1];
  assign if0.rd_dat = dat[0];    assign if1.rd_dat = dat[1];
  assign if0.rd_dat_vld = dvld[0]; assign if1.rd_dat_vld = dvld[1];
  assign if0.out_rdy = orr[0];   assign if1.out_rdy = orr[1];

  logic s_trdy[2], s_rvld[2], s_olast[2], s_done[2], s_ovld[2], s_ddrdy[2];
  logic [31:0] s_addr[2], s_odat[2];

  // Reference model: expected issue order, expected output order, memory pipeline.
  int exp_addr[2][$];
  int exp_out[2][$];
  int mem_dat[2][$];
  int mem_t[2][$];
  int remaining[2], tiles_acc[2], beat_idx[2], reqs[2], beats[2], to_send[2];
  int p_rr[2], p_or[2];
  logic done_exp[2], prev_stall[2];
  logic [31:0] prev_addr[2];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic resetModel(input int i);
    exp_addr[i].delete(); exp_out[i].delete();
    mem_dat[i].delete();  mem_t[i].delete();
    remaining[i] = 0; tiles_acc[i] = 0; beat_idx[i] = 0;
    reqs[i] = 0; beats[i] = 0; to_send[i] = 0;
    done_exp[i] = 1'b0; prev_stall[i] = 1'b0; prev_addr[i] = '0;
  endtask

  task automatic sampleOutputs();
    s_trdy[0] = if0.tile_rdy; s_rvld[0] = if0.rd_req_vld; s_olast[0] = if0.out_last;
    s_done[0] = if0.tile_done; s_ovld[0] = if0.out_vld; s_ddrdy[0] = if0.rd_dat_rdy;
    s_addr[0] = 32'(if0.rd_addr); s_odat[0] = 32'(if0.out_dat);
    s_trdy[1] = if1.tile_rdy; s_rvld[1] = if1.rd_req_vld; s_olast[1] = if1.out_last;
    s_done[1] = if1.tile_done; s_ovld[1] = if1.out_vld; s_ddrdy[1] = if1.rd_dat_rdy;
    s_addr[1] = 32'(if1.rd_addr); s_odat[1] = 32'(if1.out_dat);
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model after the rising edge.
  task automatic applyStimulus();
    logic rfire[2], ofire[2], tfire[2], exp_vld, was_last;
    int tw, a;
    for (int i = 0; i < 2; i++) begin
      rrdy[i] = (int'($urandom_range(99)) < p_rr[i]);
      orr[i]  = (int'($urandom_range(99)) < p_or[i]);
      tv[i]   = (to_send[i] > 0);
      if (mem_dat[i].size() > 0 && mem_t[i][0] <= cyc) begin
        dvld[i] = 1'b1; dat[i] = 8'(mem_dat[i][0]);
      end else begin
        dvld[i] = 1'b0; dat[i] = 8'h00;
      end
    end
    @(negedge clk);
    sampleOutputs();
    for (int i = 0; i < 2; i++) begin
      tw = rows_a[i] * cols_a[i];
`ifdef SHUFFLE_RD_CREDIT_EN
      exp_vld = (remaining[i] > 0) && ((reqs[i] - beats[i]) < MAXO);
`else
      exp_vld = (remaining[i] > 0);
`endif
      checkOutput("rd_req_vld", 32'(s_rvld[i]), 32'(exp_vld));
      rfire[i] = s_rvld[i] && rrdy[i];
      checkOutput("tile_rdy", 32'(s_trdy[i]), 32'(remaining[i] == 0 || (remaining[i] == 1 && rfire[i])));
      if (prev_stall[i]) checkOutput("addr_hold", s_addr[i], prev_addr[i]);
      if (rfire[i]) checkOutput("rd_addr", s_addr[i], (exp_addr[i].size() > 0) ? exp_addr[i][0] : -1);
      checkOutput("out_vld", 32'(s_ovld[i]), 32'(dvld[i]));
      checkOutput("rd_dat_rdy", 32'(s_ddrdy[i]), 32'(orr[i]));
      checkOutput("out_last", 32'(s_olast[i]), 32'(dvld[i] && (beat_idx[i] % tw == tw - 1)));
      ofire[i] = dvld[i] && s_ddrdy[i];
      if (ofire[i]) begin
        checkOutput("beat_expected", 32'(exp_out[i].size() > 0), 32'd1);
        if (exp_out[i].size() > 0) checkOutput("out_dat", s_odat[i], exp_out[i][0]);
      end
      checkOutput("tile_done", 32'(s_done[i]), 32'(done_exp[i]));
      tfire[i] = tv[i] && s_trdy[i];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      tw = rows_a[i] * cols_a[i];
      if (rst) begin
        resetModel(i);
      end else begin
        if (rfire[i]) begin
          mem_dat[i].push_back(int'(s_addr[i]));
          mem_t[i].push_back(cyc + 2);
          if (exp_addr[i].size() > 0) void'(exp_addr[i].pop_front());
          remaining[i]--;
          reqs[i]++;
        end
        was_last = (beat_idx[i] % tw == tw - 1);
        if (ofire[i]) begin
          void'(mem_dat[i].pop_front());
          void'(mem_t[i].pop_front());
          if (exp_out[i].size() > 0) void'(exp_out[i].pop_front());
          beat_idx[i]++;
          beats[i]++;
        end
        done_exp[i]   = ofire[i] && was_last;
        prev_stall[i] = s_rvld[i] && !rrdy[i];
        prev_addr[i]  = s_addr[i];
        if (tfire[i]) begin
          for (int c = 0; c < cols_a[i]; c++)
            for (int r = 0; r < rows_a[i]; r++) begin
              a = (tiles_acc[i] % 2) * tw + r * cols_a[i] + c;
              exp_addr[i].push_back(a);
              exp_out[i].push_back(a);
            end
          remaining[i] += tw;
          tiles_acc[i]++;
          to_send[i]--;
        end
      end
    end
  endtask

  function automatic logic busy();
    logic b = 1'b0;
    for (int i = 0; i < 2; i++)
      if (remaining[i] > 0 || to_send[i] > 0 || exp_out[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drainAll(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_timeout", 32'(busy()), 32'd0);
    repeat (4) applyStimulus();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      resetModel(i);
      p_rr[i] = 100; p_or[i] = 100;
    end
    rst = 1'b1;
    repeat (2) applyStimulus();
    rst = 1'b0;
    applyStimulus();

    $display("[TB] single tile, no stalls");
    to_send[0] = 1;
    drainAll(100);

    $display("[TB] two back-to-back tiles");
    pulseReset();
    to_send[0] = 2;
    drainAll(100);

    $display("[TB] random stalls on both instances");
    pulseReset();
    p_rr = '{60, 60}; p_or = '{50, 50};
    to_send = '{3, 2};
    drainAll(600);
    p_rr = '{100, 100}; p_or = '{100, 100};

    $display("[TB] reset after three requests");
    pulseReset();
    to_send[0] = 1;
    n = 0;
    while (reqs[0] < 3 && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("reqs_before_reset", 32'(reqs[0]), 32'd3);
    pulseReset();
    to_send[0] = 1;
    drainAll(100);

    $display("[TB] 1x4 tiles");
    pulseReset();
    to_send[1] = 2;
    drainAll(100);

`ifdef SHUFFLE_RD_CREDIT_EN
    $display("[TB] credit limit with blocked output");
    pulseReset();
    p_or[0] = 0;
    to_send[0] = 1;
    repeat (12) applyStimulus();
    checkOutput("credit_reqs", 32'(reqs[0]), 32'd2);
    p_or[0] = 100;
    drainAll(100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
